// File: rtl/tpumac_db.sv
// tpumac_db: systolic MAC processing element with double-buffered accumulator.
//   Multiplies LANES A/B operand pairs per cycle and accumulates their sum into
//   the active bank. The shadow bank drains through the Cin->Cout chain while
//   the active bank keeps accumulating. Supports signed/unsigned operands,
//   saturating or wrapping arithmetic, and a sticky overflow flag per bank.
// Ports:
//   clk, rst_n         clock / async active-low reset
//   en, clr            accumulate enable; clr restarts the active bank
//   swap               exchange active/shadow banks at this edge
//   shift_en           shadow bank loads Cin/Cin_ovf (drain step)
//   sat_en, uns        saturate vs wrap; unsigned vs signed
//   Ain, Bin           packed operand lanes, lane i at [i*BITS_AB +: BITS_AB]
//   Cin, Cin_ovf       drain chain input from upstream PE
//   Aout, Bout         registered operand forwarding
//   Cout, Cout_ovf     shadow bank value / sticky flag
//   ovf_act            active bank sticky flag
//   bank               index of active bank

// One lane: signed or unsigned BITS_AB x BITS_AB product, sign-extended to W.
module tpumac_db_lane #(
  parameter int BITS_AB = 8,
  parameter int W       = 33
) (
  input  logic [BITS_AB-1:0] a,
  input  logic [BITS_AB-1:0] b,
  input  logic               uns,
  output logic [W-1:0]       p
);
  // One extra bit lets a single signed multiplier cover both modes.
  logic signed [BITS_AB:0]     a_x, b_x;
  logic signed [2*BITS_AB+1:0] prod;

  assign a_x  = {~uns & a[BITS_AB-1], a};
  assign b_x  = {~uns & b[BITS_AB-1], b};
  assign prod = a_x * b_x;
  assign p    = {{(W-2*BITS_AB-2){prod[2*BITS_AB+1]}}, prod};
endmodule

module tpumac_db #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int LANES   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     swap,
  input  logic                     shift_en,
  input  logic                     sat_en,
  input  logic                     uns,
  input  logic [LANES*BITS_AB-1:0] Ain,
  input  logic [LANES*BITS_AB-1:0] Bin,
  input  logic [BITS_C-1:0]        Cin,
  input  logic                     Cin_ovf,
  output logic [LANES*BITS_AB-1:0] Aout,
  output logic [LANES*BITS_AB-1:0] Bout,
  output logic [BITS_C-1:0]        Cout,
  output logic                     Cout_ovf,
  output logic                     ovf_act,
  output logic                     bank
);
  // Wide enough that no lane product, lane sum or acc+sum can overflow.
  localparam int W = BITS_C + 2*BITS_AB + $clog2(LANES) + 1;

  logic [LANES-1:0][W-1:0] prod;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tpumac_db_lane #(.BITS_AB(BITS_AB), .W(W)) u_lane (
      .a   (Ain[g*BITS_AB +: BITS_AB]),
      .b   (Bin[g*BITS_AB +: BITS_AB]),
      .uns (uns),
      .p   (prod[g])
    );
  end

  // Banks are kept physically as active/shadow registers and their contents
  // exchanged on swap, so Cout comes straight off a flop.
  logic [BITS_C-1:0]        act_q, act_d, sh_q, sh_d;
  logic                     act_ovf_q, act_ovf_d, sh_ovf_q, sh_ovf_d;
  logic                     bank_q, bank_d;
  logic [LANES*BITS_AB-1:0] aout_q, aout_d, bout_q, bout_d;

  logic [W-1:0]        psum, base;
  logic signed [W-1:0] tsum, hi, lo;
  logic                ovf_now, res_ovf;
  logic [BITS_C-1:0]   res;
  logic [BITS_C-1:0]   act_c, sh_c;
  logic                act_ovf_c, sh_ovf_c;

  always_comb begin
    psum = '0;
    for (int i = 0; i < LANES; i++) psum = psum + prod[i];
    base = clr ? '0 : {{(W-BITS_C){~uns & act_q[BITS_C-1]}}, act_q};
    tsum = base + psum;
    hi   = uns ? {{(W-BITS_C){1'b0}}, {BITS_C{1'b1}}}
               : {{(W-BITS_C+1){1'b0}}, {(BITS_C-1){1'b1}}};
    lo   = uns ? '0 : {{(W-BITS_C+1){1'b1}}, {(BITS_C-1){1'b0}}};
    ovf_now = (tsum > hi) || (tsum < lo);
    res     = tsum[BITS_C-1:0];
    if (ovf_now && sat_en) res = (tsum > hi) ? hi[BITS_C-1:0] : lo[BITS_C-1:0];
    res_ovf = (~clr & act_ovf_q) | ovf_now;
  end

  // Compute and shift act on the pre-edge roles; swap then exchanges them.
  always_comb begin
    act_c     = en       ? res     : act_q;
    act_ovf_c = en       ? res_ovf : act_ovf_q;
    sh_c      = shift_en ? Cin     : sh_q;
    sh_ovf_c  = shift_en ? Cin_ovf : sh_ovf_q;
    act_d     = swap ? sh_c      : act_c;
    act_ovf_d = swap ? sh_ovf_c  : act_ovf_c;
    sh_d      = swap ? act_c     : sh_c;
    sh_ovf_d  = swap ? act_ovf_c : sh_ovf_c;
    bank_d    = bank_q ^ swap;
    aout_d    = en ? Ain : aout_q;
    bout_d    = en ? Bin : bout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= '0;
      sh_q      <= '0;
      act_ovf_q <= 1'b0;
      sh_ovf_q  <= 1'b0;
      bank_q    <= 1'b0;
      aout_q    <= '0;
      bout_q    <= '0;
    end else begin
      act_q     <= act_d;
      sh_q      <= sh_d;
      act_ovf_q <= act_ovf_d;
      sh_ovf_q  <= sh_ovf_d;
      bank_q    <= bank_d;
      aout_q    <= aout_d;
      bout_q    <= bout_d;
    end
  end

  assign Aout     = aout_q;
  assign Bout     = bout_q;
  assign Cout     = sh_q;
  assign Cout_ovf = sh_ovf_q;
  assign ovf_act  = act_ovf_q;
  assign bank     = bank_q;
endmodule

// File: tb/tb_tpumac_db.sv
// Directed bench for tpumac_db: single-lane PE, four-lane PE and a 3-PE drain
// chain. The active bank is observed by swapping it onto Cout.
module tb_tpumac_db;
  logic clk, rst_n;
  logic en, clr, swap, shift_en, sat_en, uns, cin_ovf;
  logic [7:0]  a, b, aout, bout;
  logic [15:0] cin, cout;
  logic        cout_ovf, ovf_act, bank;

  logic [31:0] a4, b4, aout4, bout4;
  logic [15:0] cout4;
  logic        cout_ovf4, ovf_act4, bank4;

  logic        ch_en, ch_clr, ch_swap, ch_shift;
  logic [7:0]  ach [3], bch [3], achq [3], bchq [3];
  logic [15:0] chin [3], chout [3];
  logic        chin_ovf [3], chout_ovf [3], ch_oact [3], ch_bank [3];

  int n_chk = 0, n_err = 0;
  logic xbank;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tpumac_db #(.BITS_AB(8), .BITS_C(16), .LANES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .swap(swap),
    .shift_en(shift_en), .sat_en(sat_en), .uns(uns), .Ain(a), .Bin(b),
    .Cin(cin), .Cin_ovf(cin_ovf), .Aout(aout), .Bout(bout), .Cout(cout),
    .Cout_ovf(cout_ovf), .ovf_act(ovf_act), .bank(bank)
  );

  tpumac_db #(.BITS_AB(8), .BITS_C(16), .LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .swap(swap),
    .shift_en(shift_en), .sat_en(sat_en), .uns(uns), .Ain(a4), .Bin(b4),
    .Cin(cin), .Cin_ovf(cin_ovf), .Aout(aout4), .Bout(bout4), .Cout(cout4),
    .Cout_ovf(cout_ovf4), .ovf_act(ovf_act4), .bank(bank4)
  );

  assign chin[0] = 16'd0;
  assign chin[1] = chout[0];
  assign chin[2] = chout[1];
  assign chin_ovf[0] = 1'b0;
  assign chin_ovf[1] = chout_ovf[0];
  assign chin_ovf[2] = chout_ovf[1];

  for (genvar k = 0; k < 3; k++) begin : g_chain
    tpumac_db #(.BITS_AB(8), .BITS_C(16), .LANES(1)) u_pe (
      .clk(clk), .rst_n(rst_n), .en(ch_en), .clr(ch_clr), .swap(ch_swap),
      .shift_en(ch_shift), .sat_en(sat_en), .uns(uns), .Ain(ach[k]),
      .Bin(bch[k]), .Cin(chin[k]), .Cin_ovf(chin_ovf[k]), .Aout(achq[k]),
      .Bout(bchq[k]), .Cout(chout[k]), .Cout_ovf(chout_ovf[k]),
      .ovf_act(ch_oact[k]), .bank(ch_bank[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    if (swap) xbank = ~xbank;
    @(posedge clk);
    #1;
  endtask

  initial begin
    {en, clr, swap, shift_en, sat_en, uns, cin_ovf} = '0;
    a = '0; b = '0; cin = '0; a4 = '0; b4 = '0;
    {ch_en, ch_clr, ch_swap, ch_shift} = '0;
    for (int k = 0; k < 3; k++) begin ach[k] = '0; bch[k] = '0; end
    xbank = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_cout", cout, 16'h0000);
    chk("rst_bank", bank, 1'b0);
    chk("rst_aout", aout, 8'h00);
    chk("rst_ovf", {ovf_act, cout_ovf}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic MAC: 3*4 = 12, then 12 + (-2*5) = 2
    en = 1; clr = 1; a = 8'd3; b = 8'd4; tick();
    chk("aout_lag", aout, 8'h03);
    chk("ovf_basic", ovf_act, 1'b0);
    en = 0; clr = 0; a = 8'd9; swap = 1; tick();
    chk("aout_hold", aout, 8'h03);
    chk("acc_12", cout, 16'h000C);
    chk("bank_sw", bank, xbank);
    tick();
    chk("bank_back", bank, 1'b0);
    en = 1; a = 8'hFE; b = 8'd5; tick();
    chk("acc_2", cout, 16'h0002);
    chk("aout_fe", aout, 8'hFE);
    chk("bout_5", bout, 8'h05);
    en = 0; swap = 0;

    // Reset pulse mid-cycle discards everything
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_cout", cout, 16'h0000);
    chk("mrst_bank", bank, 1'b0);
    chk("mrst_aout", aout, 8'h00);
    #2 rst_n = 1'b1; xbank = 1'b0;
    @(posedge clk); #1;

    // Saturate vs wrap from acc = 32000, adding 100*10
    shift_en = 1; cin = 16'd32000; cin_ovf = 0; swap = 1; tick();
    shift_en = 0; swap = 0; en = 1; sat_en = 1; a = 8'd100; b = 8'd10; tick();
    chk("sat_ovf", ovf_act, 1'b1);
    en = 0; swap = 1; shift_en = 1; cin = 16'd32000; tick();
    chk("sat_val", cout, 16'h7FFF);
    chk("sat_flag", cout_ovf, 1'b1);
    chk("reload_ovf", ovf_act, 1'b0);
    swap = 0; shift_en = 0; en = 1; sat_en = 0; tick();
    chk("wrap_ovf", ovf_act, 1'b1);
    en = 0; swap = 1; shift_en = 1; cin = 16'd0; cin_ovf = 1; tick();
    chk("wrap_val", cout, 16'h80E8);
    chk("wrap_flag", cout_ovf, 1'b1);
    chk("cin_ovf_in", ovf_act, 1'b1);
    swap = 0; shift_en = 0; cin_ovf = 0; en = 1; clr = 1; a = 8'd1; b = 8'd1; tick();
    chk("clr_flag", ovf_act, 1'b0);
    en = 0; clr = 1; swap = 1; tick();
    chk("clr_no_en", cout, 16'h0001);
    clr = 0; swap = 0;

    // Unsigned: 255*255 = 65025; second add saturates; wrap gives 0xFC02
    uns = 1; sat_en = 1; en = 1; clr = 1; a = 8'hFF; b = 8'hFF; tick();
    chk("uns_ovf0", ovf_act, 1'b0);
    en = 0; clr = 0; swap = 1; tick();
    chk("uns_65025", cout, 16'hFE01);
    tick();
    en = 1; tick();
    chk("uns_sat", cout, 16'hFFFF);
    chk("uns_sat_f", cout_ovf, 1'b1);
    swap = 0; clr = 1; sat_en = 0; tick();
    clr = 0; swap = 1; tick();
    chk("uns_wrap", cout, 16'hFC02);
    en = 0; swap = 0; uns = 0; a = 0; b = 0;

    // Multi-lane: 1*5 - 2*6 + 3*(-7) + 4*8 = 4, then 4 * 16384 saturates
    en = 1; clr = 1; swap = 1;
    a4 = {8'd1, 8'hFE, 8'd3, 8'd4}; b4 = {8'd5, 8'd6, 8'hF9, 8'd8}; tick();
    chk("lane4_sum", cout4, 16'h0004);
    chk("lane4_ovf", cout_ovf4, 1'b0);
    a4 = 32'h80808080; b4 = 32'h80808080; sat_en = 1; tick();
    chk("lane4_sat", cout4, 16'h7FFF);
    chk("lane4_satf", cout_ovf4, 1'b1);
    chk("lane4_aout", aout4, 32'h80808080);
    en = 0; clr = 0; swap = 0;

    // Simultaneous en+shift+swap; active base becomes Cin=7
    en = 1; clr = 1; a = 8'd1; b = 8'd5; sat_en = 0; tick();
    clr = 0; a = 8'd2; b = 8'd3; shift_en = 1; cin = 16'd7; cin_ovf = 1; swap = 1; tick();
    chk("sim_cout", cout, 16'h000B);
    chk("sim_coutf", cout_ovf, 1'b0);
    chk("sim_oact", ovf_act, 1'b1);
    chk("sim_bank", bank, xbank);
    shift_en = 0; cin_ovf = 0; a = 8'd1; b = 8'd1; tick();
    chk("sim_base7", cout, 16'h0008);
    chk("sim_sticky", cout_ovf, 1'b1);
    en = 0; swap = 0;

    // 3-PE chain: 20, 32767(ovf), 60 drain as PE2, PE1, PE0
    sat_en = 1; ch_en = 1; ch_clr = 1;
    ach[0] = 8'd1; bch[0] = 8'd10;
    ach[1] = 8'h80; bch[1] = 8'h80;
    ach[2] = 8'd3; bch[2] = 8'd10; tick();
    ch_clr = 0; tick();
    ch_en = 0; ch_swap = 1; tick();
    chk("chain_pe2", chout[2], 16'h003C);
    chk("chain_pe2f", chout_ovf[2], 1'b0);
    ch_swap = 0; ch_shift = 1; ch_en = 1; ch_clr = 1;
    for (int k = 0; k < 3; k++) begin ach[k] = 8'd2; bch[k] = 8'd3; end
    tick();
    chk("chain_pe1", chout[2], 16'h7FFF);
    chk("chain_pe1f", chout_ovf[2], 1'b1);
    ch_clr = 0; tick();
    chk("chain_pe0", chout[2], 16'h0014);
    chk("chain_pe0f", chout_ovf[2], 1'b0);
    tick();
    chk("chain_empty", chout[2], 16'h0000);
    ch_shift = 0; ch_en = 0; ch_swap = 1; tick();
    chk("chain_act2", chout[2], 16'h0012);
    chk("chain_act0", chout[0], 16'h0012);
    chk("chain_actf", chout_ovf[2], 1'b0);
    ch_swap = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tpumac_db.md
Name: tpumac_db

Overview:
- Next-generation systolic MAC processing element.
- Multiplies LANES pairs of A/B operands per cycle and accumulates their sum into one of two accumulator banks.
- Forwards A/B to its neighbours with a one-cycle delay, like the current PE.
- The second (shadow) bank drains results down a Cin->Cout shift chain while the active bank keeps accumulating; adds a saturation mode, an unsigned mode and per-bank sticky overflow.

Parameters:
- BITS_AB, 8, width of each A/B operand lane.
- BITS_C, 16, accumulator and C-chain width.
- LANES, 1, operand pairs multiplied and summed per cycle (>=1).

Ports:
- clk  in  1  clock, all registers on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  compute enable: accumulate into active bank, register A/B forwarding.
- clr  in  1  with en: active bank loads this cycle's product sum instead of acc+sum.
- swap  in  1  exchange active/shadow banks at this edge.
- shift_en  in  1  shadow bank loads Cin/Cin_ovf (drain chain step).
- sat_en  in  1  1 = saturate on overflow, 0 = wrap modulo 2^BITS_C.
- uns  in  1  1 = operands and accumulator unsigned, 0 = two's-complement signed.
- Ain  in  LANES*BITS_AB  A operands, lane i at [i*BITS_AB +: BITS_AB].
- Bin  in  LANES*BITS_AB  B operands, same packing.
- Cin  in  BITS_C  drain chain input from upstream PE.
- Cin_ovf  in  1  overflow flag travelling with Cin.
- Aout  out  LANES*BITS_AB  registered Ain.
- Bout  out  LANES*BITS_AB  registered Bin.
- Cout  out  BITS_C  shadow bank contents, driven straight from the register.
- Cout_ovf  out  1  shadow bank sticky overflow flag.
- ovf_act  out  1  active bank sticky overflow flag.
- bank  out  1  index of active bank.

Behaviour:
- Reset (async, rst_n=0): acc0=acc1=0, both ovf flags 0, bank=0, Aout=Bout=0. Outputs are valid 0 while reset is asserted.
- Reset mid-accumulation discards both banks. There is no partial-result preservation.
- A/B forwarding: if en, Aout<=Ain and Bout<=Bin; otherwise hold. Latency 1 cycle.
- Product sum P = sum over lanes of Ain[i]*Bin[i].
  - Each product is 2*BITS_AB wide, signed or unsigned per uns.
  - Extend to W = BITS_C+2*BITS_AB+clog2(LANES)+1 bits before summing. There is no intermediate overflow.
- Compute, when en=1:
  - base = clr ? 0 : acc[bank] (extended to W per uns).
  - T = base + P.
  - Range: signed [-2^(BITS_C-1), 2^(BITS_C-1)-1]; unsigned [0, 2^BITS_C-1].
  - If T is out of range, set ovf = 1. Then acc[bank] <= nearest range bound if sat_en, else T[BITS_C-1:0].
  - ovf[bank] <= (clr ? 0 : ovf[bank]) | ovf.
- en=0: active bank and its flag hold. clr without en has no effect.
- Drain, when shift_en=1: acc[~bank]<=Cin and ovf[~bank]<=Cin_ovf. This is independent of en.
- Swap, when swap=1: bank<=~bank at the edge. Flags travel with their banks.
- Simultaneous events in one cycle are all evaluated against the pre-edge bank:
  - compute writes the old active bank;
  - shift writes the old shadow bank;
  - then the roles exchange.
  - Example: en+shift_en+swap makes the freshly shifted-in value the new active bank, and the just-computed value the new shadow on Cout.
- Cout/Cout_ovf show the shadow bank post-edge. There is no combinational path from any input to any output.
- The mode inputs uns/sat_en are sampled per cycle. Changing them mid-accumulation is legal and takes effect on that cycle's operation.
- Chaining: PE k Cout -> PE k+1 Cin. N PEs drain in N shift cycles.

Test Plan:
- Reset and basic MAC:
  - Stimulus: rst_n pulse mid-cycle, then signed LANES=1, en=1, clr=1 with A=3,B=4, then A=-2,B=5 (clr=0).
  - Required: after reset all outputs 0; acc=12 then 2, ovf_act=0, Aout lags Ain by one cycle.
- Saturate vs wrap:
  - Stimulus: signed BITS_C=16, acc=32000, A=100,B=10.
  - Required: sat_en=1 -> acc=32767, ovf_act=1; sat_en=0 -> acc=(33000-65536)=-32536, ovf_act=1; clr&en next cycle clears flag.
- Unsigned mode:
  - Stimulus: uns=1, A=8'hFF,B=8'hFF, clr=1.
  - Required: acc=65025; a second accumulate saturates to 65535 when sat_en=1.
- Multi-lane:
  - Stimulus: LANES=4, signed, A={1,-2,3,4}, B={5,6,-7,8}, clr=1.
  - Required: acc=5-12-21+32=4.
- Ping-pong drain:
  - Stimulus: chain of 3 PEs, all accumulate, assert swap one cycle, then shift_en 3 cycles while en continues.
  - Required: results emerge at last Cout in order PE2,PE1,PE0 with matching Cout_ovf; the active banks keep accumulating unaffected.
- Simultaneous:
  - Stimulus: en+shift_en+swap in the same cycle with Cin=7.
  - Required: next cycle bank toggled, ovf_act reflects Cin_ovf, accumulation base is 7; Cout equals the value computed that cycle.
